// File: rtl/adsr_pkg.sv
// Shared types for the ADSR envelope: state encoding and default level geometry.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  localparam int unsigned ENV_LW = 16;
  localparam logic [ENV_LW-1:0] ENV_FULL_SCALE = 16'hFFFF;

endpackage

// File: rtl/adsr_envelope_sample_scaler.sv
// Two-stage signed sample x unsigned gain multiplier; result is the product
// shifted right arithmetically by LW (floor), valid travels with the data.
module sample_scaler #(
  parameter int OW = 24,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [OW-1:0] in_data,
  input  logic [LW-1:0] gain,
  output logic          out_valid,
  output logic [OW-1:0] out_data
);

  localparam int PW = OW + LW + 1;

  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] prod_r;
  logic signed [PW-1:0] shift_s;
  logic                 valid1_r;
  logic                 valid2_r;
  logic [OW-1:0]        data2_r;

  // Gain is zero-extended so it stays non-negative in the signed multiply.
  assign prod_s  = PW'($signed(in_data)) * PW'($signed({1'b0, gain}));
  assign shift_s = prod_r >>> LW;

  // Stage 1: register the full-width product.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r   <= {PW{1'b0}};
      valid1_r <= 1'b0;
    end else begin
      prod_r   <= prod_s;
      valid1_r <= in_valid;
    end
  end

  // Stage 2: register the shifted, truncated result.
  always_ff @(posedge clk) begin
    if (rst) begin
      data2_r  <= {OW{1'b0}};
      valid2_r <= 1'b0;
    end else begin
      data2_r  <= shift_s[OW-1:0];
      valid2_r <= valid1_r;
    end
  end

  assign out_valid = valid2_r;
  assign out_data  = data2_r;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: per-sample state/level update on in_valid, and the
// incoming sample scaled by the pre-update level through a 2-stage scaler.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int OW = 24,
  parameter int LW = ENV_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [OW-1:0] in_data,
  input  logic          gate,
  input  logic [LW-1:0] attack_step,
  input  logic [LW-1:0] decay_step,
  input  logic [LW-1:0] sustain_level,
  input  logic [LW-1:0] release_step,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic [LW-1:0] env_level,
  output logic [2:0]    env_state,
  output logic          busy
);

  localparam logic [LW:0] FULL = {1'b0, {LW{1'b1}}};

  adsr_state_t   state_r, state_nxt_s;
  logic [LW-1:0] level_r, level_nxt_s;
  logic          gate_q_r;
  logic          busy_r;
  logic          gate_rise_s;
  logic [LW:0]   atk_sum_s, dec_diff_s, rel_diff_s, atk_rel_diff_s;
  logic          atk_full_s, dec_hit_s;
  logic [LW-1:0] atk_lvl_s, rel_lvl_s, atk_rel_lvl_s;

  assign gate_rise_s    = gate & ~gate_q_r;
  assign atk_sum_s      = {1'b0, level_r} + {1'b0, attack_step};
  assign atk_full_s     = (atk_sum_s >= FULL);
  assign atk_lvl_s      = atk_full_s ? FULL[LW-1:0] : atk_sum_s[LW-1:0];
  assign dec_diff_s     = {1'b0, level_r} - {1'b0, decay_step};
  assign dec_hit_s      = dec_diff_s[LW] | (dec_diff_s[LW-1:0] <= sustain_level);
  assign rel_diff_s     = {1'b0, level_r} - {1'b0, release_step};
  assign rel_lvl_s      = rel_diff_s[LW] ? {LW{1'b0}} : rel_diff_s[LW-1:0];
  // Gate dropping during ATTACK releases from the (possibly saturated) attack result.
  assign atk_rel_diff_s = {1'b0, atk_lvl_s} - {1'b0, release_step};
  assign atk_rel_lvl_s  = atk_rel_diff_s[LW] ? {LW{1'b0}} : atk_rel_diff_s[LW-1:0];

  // Next state and level, evaluated only on sample strobes.
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    if (in_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (gate_rise_s) begin
            state_nxt_s = atk_full_s ? ST_DECAY : ST_ATTACK;
            level_nxt_s = atk_lvl_s;
          end else begin
            state_nxt_s = ST_IDLE;
            level_nxt_s = {LW{1'b0}};
          end
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_nxt_s = ST_RELEASE;
            level_nxt_s = atk_rel_lvl_s;
          end else begin
            state_nxt_s = atk_full_s ? ST_DECAY : ST_ATTACK;
            level_nxt_s = atk_lvl_s;
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_nxt_s = ST_RELEASE;
            level_nxt_s = rel_lvl_s;
          end else if (dec_hit_s) begin
            state_nxt_s = ST_SUSTAIN;
            level_nxt_s = sustain_level;
          end else begin
            state_nxt_s = ST_DECAY;
            level_nxt_s = dec_diff_s[LW-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            state_nxt_s = ST_RELEASE;
            level_nxt_s = rel_lvl_s;
          end else begin
            state_nxt_s = ST_SUSTAIN;
            level_nxt_s = sustain_level;
          end
        end
        ST_RELEASE: begin
          if (gate_rise_s) begin
            state_nxt_s = atk_full_s ? ST_DECAY : ST_ATTACK;
            level_nxt_s = atk_lvl_s;
          end else if (rel_lvl_s == {LW{1'b0}}) begin
            state_nxt_s = ST_IDLE;
            level_nxt_s = {LW{1'b0}};
          end else begin
            state_nxt_s = ST_RELEASE;
            level_nxt_s = rel_lvl_s;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          level_nxt_s = {LW{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      level_nxt_s = level_r;
    end
  end

  // Envelope state, level, captured gate and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      level_r  <= {LW{1'b0}};
      gate_q_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      level_r  <= level_nxt_s;
      gate_q_r <= in_valid ? gate : gate_q_r;
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  sample_scaler #(.OW(OW), .LW(LW)) u_scaler (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .gain      (level_r),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign env_level = level_r;
  assign env_state = state_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized
// traffic, all compared against an integer-arithmetic envelope model.
module tb_adsr_envelope;

  localparam int OW = 24;
  localparam int LW = 16;
  localparam int FS = 65535;

  logic          clk = 1'b0;
  logic          rst, in_valid, gate;
  logic [OW-1:0] in_data;
  logic [LW-1:0] attack_step, decay_step, sustain_level, release_step;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [LW-1:0] env_level;
  logic [2:0]    env_state;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // model state: level, phase (0 idle,1 attack,2 decay,3 sustain,4 release), previous gate
  int m_lvl = 0;
  int m_st  = 0;
  bit m_gq  = 1'b0;
  bit pv1 = 1'b0, pv2 = 1'b0;
  int pd1 = 0, pd2 = 0;
  int obs_q[$];

  always #5 clk = ~clk;

  adsr_envelope #(.OW(OW), .LW(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .env_level     (env_level),
    .env_state     (env_state),
    .busy          (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int sub0(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  task automatic model_attack();
    int s;
    s = m_lvl + int'(attack_step);
    if (s >= FS) begin
      m_lvl = FS;
      m_st  = 2;
    end else begin
      m_lvl = s;
      m_st  = 1;
    end
  endtask

  task automatic model_sample();
    bit rise;
    int top;
    rise = gate && !m_gq;
    case (m_st)
      0: if (rise) model_attack();
      1: begin
        if (!gate) begin
          top   = m_lvl + int'(attack_step);
          if (top > FS) top = FS;
          m_lvl = sub0(top, int'(release_step));
          m_st  = 4;
        end else model_attack();
      end
      2: begin
        if (!gate) begin
          m_lvl = sub0(m_lvl, int'(release_step));
          m_st  = 4;
        end else if (m_lvl - int'(decay_step) <= int'(sustain_level)) begin
          m_lvl = int'(sustain_level);
          m_st  = 3;
        end else m_lvl = m_lvl - int'(decay_step);
      end
      3: begin
        if (!gate) begin
          m_lvl = sub0(m_lvl, int'(release_step));
          m_st  = 4;
        end else m_lvl = int'(sustain_level);
      end
      4: begin
        if (rise) model_attack();
        else begin
          m_lvl = sub0(m_lvl, int'(release_step));
          if (m_lvl == 0) m_st = 0;
        end
      end
      default: m_st = 0;
    endcase
    m_gq = gate;
  endtask

  // One clock: apply a sample, advance the model, check all outputs #1 after the edge.
  task automatic cycle(input bit v, input int d);
    int e;
    logic [31:0] dv;
    dv       = d;
    in_valid = v;
    in_data  = dv[OW-1:0];
    e = int'((longint'(d) * longint'(m_lvl)) >>> 16);
    pv2 = pv1; pd2 = pd1; pv1 = v; pd1 = e;
    if (rst) begin
      m_lvl = 0; m_st = 0; m_gq = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
    end else if (v) model_sample();
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(pv2));
    if (pv2) chk("out_data", int'($signed(out_data)), pd2);
    if (out_valid) obs_q.push_back(int'($signed(out_data)));
    chk("env_level", int'(env_level), m_lvl);
    chk("env_state", int'(env_state), m_st);
    chk("busy", int'(busy), int'(m_st != 0));
  endtask

  initial begin
    int atk_lv[4];
    int atk_out[4];
    int dec_lv[4];
    int rel_lv[3];
    logic [OW-1:0] r;
    atk_lv  = '{32'h4000, 32'h8000, 32'hC000, 32'hFFFF};
    atk_out = '{32'h000000, 32'h040000, 32'h080000, 32'h0C0000};
    dec_lv  = '{32'hEFFF, 32'hDFFF, 32'hCFFF, 32'hC000};
    rel_lv  = '{32'h8000, 32'h4000, 32'h0000};

    rst = 1'b1; gate = 1'b0; in_valid = 1'b0; in_data = 24'h0;
    attack_step = 16'h0; decay_step = 16'h0; sustain_level = 16'h0; release_step = 16'h0;

    // reset with toggling in_valid
    for (int i = 0; i < 3; i++) begin
      cycle(i % 2 == 0, 32'h1234);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 0);
      chk("post_rst_out_valid", int'(out_valid), 0);
    end

    // attack
    attack_step = 16'h4000; decay_step = 16'h1000;
    sustain_level = 16'hC000; release_step = 16'h4000;
    gate = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h100000);
      chk("atk_level", int'(env_level), atk_lv[i]);
    end
    chk("atk_to_decay", int'(env_state), 2);

    // decay into sustain
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h100000);
      chk("dec_level", int'(env_level), dec_lv[i]);
    end
    chk("dec_to_sustain", int'(env_state), 3);
    chk("atk_out_count", int'(obs_q.size() >= 4), 1);
    for (int i = 0; i < 4; i++) chk("atk_out_data", obs_q[i], atk_out[i]);
    sustain_level = 16'hA000;
    cycle(1'b1, 32'h100000);
    chk("sus_track", int'(env_level), 32'hA000);
    sustain_level = 16'hC000;
    cycle(1'b1, 32'h100000);
    chk("sus_back", int'(env_level), 32'hC000);

    // release to idle
    gate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h100000);
      chk("rel_level", int'(env_level), rel_lv[i]);
    end
    chk("rel_to_idle", int'(env_state), 0);

    // climb again, release once, retrigger at 0x8000
    gate = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100000);
    chk("resustain", int'(env_level), 32'hC000);
    gate = 1'b0;
    cycle(1'b1, 32'h100000);
    chk("rel_half", int'(env_level), 32'h8000);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    obs_q.delete();
    gate = 1'b1;
    cycle(1'b1, -32'sh100000);
    chk("retrig_state", int'(env_state), 1);
    chk("retrig_level", int'(env_level), 32'hC000);
    cycle(1'b1, 32'h100);
    chk("retrig_sat", int'(env_level), 32'hFFFF);
    cycle(1'b1, -32'sh800000);

    // gap: level/state hold, pipeline drains then stays quiet
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h55);
      if (i >= 2) chk("gap_out_valid", int'(out_valid), 0);
      chk("gap_level", int'(env_level), 32'hEFFF);
      chk("gap_state", int'(env_state), 2);
    end
    chk("neg_count", int'(obs_q.size()), 3);
    chk("neg_half", obs_q[0], -32'sh080000);
    chk("neg_full", obs_q[2], -32'sh7FFF80);

    // back to idle, attack to 0x8000, reset mid-attack with gate held high
    gate = 1'b0; release_step = 16'hFFFF;
    cycle(1'b1, 32'h10);
    cycle(1'b1, 32'h10);
    chk("fast_idle", int'(env_state), 0);
    gate = 1'b1; release_step = 16'h4000;
    cycle(1'b1, 32'h10);
    cycle(1'b1, 32'h10);
    chk("mid_atk", int'(env_level), 32'h8000);
    rst = 1'b1;
    cycle(1'b1, 32'h10);
    chk("rst_mid_level", int'(env_level), 0);
    chk("rst_mid_state", int'(env_state), 0);
    rst = 1'b0;
    cycle(1'b1, 32'h10);
    chk("rst_gate_rise", int'(env_state), 1);
    chk("rst_gate_level", int'(env_level), 32'h4000);

    // saturation and gate low on the same sample
    cycle(1'b1, 32'h10);
    cycle(1'b1, 32'h10);
    gate = 1'b0; release_step = 16'h1000;
    cycle(1'b1, 32'h10);
    chk("sat_gate_low_state", int'(env_state), 4);
    chk("sat_gate_low_level", int'(env_level), 32'hEFFF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) begin
        attack_step   = 16'($urandom_range(0, 32'h3000));
        decay_step    = 16'($urandom_range(0, 32'h1000));
        sustain_level = 16'($urandom_range(0, 32'hFFFF));
        release_step  = 16'($urandom_range(0, 32'h2000));
      end
      rst = ($urandom_range(0, 299) == 0);
      r = OW'($urandom());
      cycle($urandom_range(0, 3) != 0, int'($signed(r)));
    end
    rst = 1'b0;
    cycle(1'b0, 0);
    cycle(1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-sample ADSR (attack/decay/sustain/release) amplitude envelope applied to a signed sample stream. It sits directly downstream of the DDS tone generator: it consumes the generator's `valid`/`ampl` pair, scales each sample by an envelope gain, and drives the result onward. A `gate` input triggers the envelope; all rates and the sustain level are run-time inputs.

## Interface
- `OW`, 24: sample width, signed two's complement, input and output.
- `LW`, 16: envelope level width, unsigned; full scale is `2**LW-1`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: sample strobe; connects to DDS `valid`.
- `in_data` in OW: signed sample; connects to DDS `ampl`.
- `gate` in 1: note on (1) / note off (0).
- `attack_step` in LW: level increment per sample in ATTACK.
- `decay_step` in LW: level decrement per sample in DECAY.
- `sustain_level` in LW: SUSTAIN target level.
- `release_step` in LW: level decrement per sample in RELEASE.
- `out_valid` out 1: output strobe.
- `out_data` out OW: scaled signed sample.
- `env_level` out LW: current envelope level.
- `env_state` out 3: encoding is IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `busy` out 1: high whenever `env_state != IDLE`.

## Operation
- **Update rule.**
  - State and level update only on `in_valid` cycles. Without `in_valid`, everything holds.
  - `gate` is sampled only on `in_valid` cycles.
  - `gate_q` is the gate value captured at the previous `in_valid`.
  - A rising edge is `gate & ~gate_q`.
- **Gain used for output.** Each sample is scaled by the `env_level` value before that sample's update.
- **IDLE.**
  - Level is 0.
  - On a rising edge, go to ATTACK and apply the first attack step on the same sample.
- **ATTACK.**
  - Next level is `env + attack_step`, computed in LW+1 bits.
  - If the sum is at or above `2**LW-1`, the level saturates to `2**LW-1` and the state moves to DECAY.
- **DECAY.**
  - Next level is `env - decay_step`, computed in LW+1 bits.
  - If the result is at or below `sustain_level`, the level becomes `sustain_level` and the state moves to SUSTAIN.
- **SUSTAIN.** The level tracks `sustain_level` every sample, including live changes to it.
- **RELEASE.**
  - Next level is `env - release_step`, floored at 0.
  - Reaching 0 moves the state to IDLE.
- **Gate edges.**
  - `gate` low in ATTACK, DECAY or SUSTAIN: go to RELEASE. The release step is applied on that same sample.
  - Rising edge in RELEASE: retrigger to ATTACK from the current level, not from 0.
- **Zero steps.** A step of 0 holds the level and the state indefinitely. This is legal and is not an error.
- **Scaling.**
  - `out_data = (in_data * {1'b0, env}) >>> LW`, a signed multiply.
  - The shift is arithmetic and truncates (floors).
  - Overflow is impossible because the maximum gain is `(2**LW-1)/2**LW`.

## Timing
- **Latency.** `out_valid`/`out_data` appear exactly 2 cycles after the corresponding `in_valid`.
  - Stage 1 registers the product.
  - Stage 2 registers the shifted result.
- **Throughput.** Back-to-back `in_valid` is supported at one sample per clock.
- **Gaps.** `in_valid` gaps propagate one-for-one to `out_valid`.
- **Output visibility.** `env_level` and `env_state` are registered; the new values are visible the cycle after the `in_valid` that updated them.
- **Reset values.**
  - `out_valid=0`, `out_data=0`, `env_level=0`, `env_state=IDLE`, `busy=0`.
  - `gate_q=0` and both pipeline valid bits are 0.
- **Reset mid-operation.**
  - State and level return to IDLE/0 on the next edge.
  - In-flight samples are dropped: no `out_valid` for 2 cycles after `rst` deasserts.
  - A gate held high through reset produces a rising edge at the first `in_valid` after reset, because `gate_q` is cleared.
- **Simultaneous events.**
  - `rst` with `in_valid` high: reset wins.
  - ATTACK saturation and gate low on the same sample: gate low wins, so the state goes to RELEASE with `env_level = 2**LW-1 - release_step`, floored at 0.

## Structure
- **Package `adsr_pkg`.**
  - State enum `adsr_state_t` (3 bits, encodings as above).
  - Localparam for the full-scale level.
- **Sub-module `sample_scaler`.**
  - 2-stage pipelined signed×unsigned multiply with arithmetic shift.
  - Parameters OW and LW; valid passes alongside the data.
  - Reusable for a fixed gain/volume stage.
- **Top level.** Holds the state machine, level register, `gate_q` and the saturation arithmetic.

## Test plan
All scenarios use OW=24, LW=16.

1. **Reset.** Assert `rst` for 3 cycles with `in_valid` toggling -> all outputs 0, `env_state=0`, no `out_valid` during reset or in the 2 cycles after it.
2. **Attack.**
   - Stimulus: `attack_step=0x4000`, `in_data=0x100000`, `gate` high, `in_valid` every cycle.
   - Required: `env_level` goes 0x4000, 0x8000, 0xC000, 0xFFFF, and the state is DECAY after the 4th sample.
   - Required: `out_data` is 0x000000, 0x040000, 0x080000, 0x0C0000.
3. **Decay and sustain.**
   - Stimulus: `decay_step=0x1000`, `sustain_level=0xC000`.
   - Required: level goes 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 with the state SUSTAIN.
   - Required: changing `sustain_level` to 0xA000 gives level 0xA000 on the next sample.
4. **Release and retrigger.**
   - Stimulus: `gate` low at level 0xC000 with `release_step=0x4000`.
   - Required: level goes 0x8000, 0x4000, 0x0000 and the state is IDLE.
   - Repeat, but raise `gate` at level 0x8000: the state is ATTACK and the level is 0xC000 on that sample.
5. **Negative samples.**
   - `in_data=-0x100000` at level 0x8000 -> `out_data=-0x080000`.
   - `in_data=-0x800000` at level 0xFFFF -> `out_data=-0x7FFF80`.
6. **Gaps and reset mid-attack.**
   - `in_valid` low for 5 cycles -> level and state hold, and there are no extra `out_valid` pulses.
   - `rst` during ATTACK at level 0x8000 -> IDLE with level 0 on the next edge.
